// File: rtl/mcu_pkg.sv
// Shared definitions for the coprocessor control unit.
//   state_t       : control FSM states
//   CFG_*         : config word field positions beyond the gamma/lambda fields
//   STAT_*        : status word bit positions
//   next_ptr      : round-robin pointer successor (c + 1 mod n)
package mcu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_REQ      = 4'd1,
        ST_RD_ADDR  = 4'd2,
        ST_RD_DATA  = 4'd3,
        ST_DISPATCH = 4'd4,
        ST_DRAIN    = 4'd5,
        ST_WR_REQ   = 4'd6,
        ST_WR       = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    // 0 = row-major (column advances fastest), 1 = column-major
    localparam int CFG_ORDER_BIT     = 31;

    localparam int STAT_DONE_BIT     = 0;
    localparam int STAT_ERR_DIM_BIT  = 1;
    localparam int STAT_ERR_SPUR_BIT = 2;
    localparam int STAT_CNT_LSB      = 16;

    function automatic int next_ptr(input int c, input int n);
        return (c + 1 >= n) ? 0 : c + 1;
    endfunction

endpackage

// File: rtl/main_cu_multi_rr_pick.sv
// Round-robin first-free selector.
//   i_Free   : per-channel free mask (1 = channel can take a pair)
//   i_Ptr    : search start position
//   o_Onehot : one-hot of the first free channel at or after i_Ptr (wrapping)
//   o_Index  : binary index of that channel
//   o_Valid  : at least one channel is free
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_Free,
    input  logic [PW-1:0] i_Ptr,
    output logic [N-1:0]  o_Onehot,
    output logic [PW-1:0] o_Index,
    output logic          o_Valid
);

    int            j;
    logic [PW-1:0] jj;

    always_comb begin
        o_Onehot = '0;
        o_Index  = '0;
        o_Valid  = 1'b0;
        j        = 0;
        jj       = '0;
        for (int i = 0; i < N; i++) begin
            j  = (int'(i_Ptr) + i) % N;
            jj = PW'(j);
            if (!o_Valid && i_Free[jj]) begin
                o_Valid      = 1'b1;
                o_Onehot[jj] = 1'b1;
                o_Index      = jj;
            end
        end
    end

endmodule

// File: rtl/main_cu_multi.sv
// Coprocessor control unit for NUM_CH processing channels.
// Reads a config word (gamma rows, lambda cols, order bit), hands every
// (row, col) pair to free channels in round-robin order, counts results,
// writes a status word and releases the bus.
//
// Ports
//   i_Clock, i_Reset        clock, synchronous active-high reset
//   i_Data_Ready            start request (level)
//   i_Grant / o_Grant_Request  memory bus handshake
//   i_Mem_Data              read data, valid the cycle after the address
//   o_Memory_Address, o_Mem_Data, o_Write_Enable  memory access
//   o_Config                latched config word
//   o_Indexes_Ready / i_Indexes_Received  per-channel pair handshake
//   o_Row_Index, o_Column_Index  per-channel pair, channel c at [c*IDX_W +: IDX_W]
//   i_Result_Ready          per-channel result pulse
//   o_Busy                  FSM not idle
//
// state       | meaning
// ST_IDLE     | waiting for i_Data_Ready
// ST_REQ      | requesting the bus
// ST_RD_ADDR  | config address on the bus
// ST_RD_DATA  | config data returned, latched here
// ST_DISPATCH | offering index pairs to free channels
// ST_DRAIN    | all pairs issued, waiting for outstanding results
// ST_WR_REQ   | requesting the bus for the status write
// ST_WR       | status write (held while grant is low)
// ST_DONE     | job finished, waiting for i_Data_Ready to fall
module main_cu_multi
    import mcu_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDX_W       = 8,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int CFG_ADDR    = 0,
    parameter int STATUS_ADDR = 1
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Data_Ready,
    input  logic                    i_Grant,
    input  logic [DATA_W-1:0]       i_Mem_Data,
    input  logic [NUM_CH-1:0]       i_Indexes_Received,
    input  logic [NUM_CH-1:0]       i_Result_Ready,
    output logic                    o_Grant_Request,
    output logic [ADDR_W-1:0]       o_Memory_Address,
    output logic [DATA_W-1:0]       o_Mem_Data,
    output logic                    o_Write_Enable,
    output logic [DATA_W-1:0]       o_Config,
    output logic [NUM_CH-1:0]       o_Indexes_Ready,
    output logic [NUM_CH*IDX_W-1:0] o_Row_Index,
    output logic [NUM_CH*IDX_W-1:0] o_Column_Index,
    output logic                    o_Busy
);

    localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = 2 * IDX_W;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   config_q, config_d;
    logic [IDX_W-1:0]    row_q, row_d;
    logic [IDX_W-1:0]    col_q, col_d;
    logic [NUM_CH-1:0]   busy_q, busy_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
    logic                err_dim_q, err_dim_d;
    logic                err_spur_q, err_spur_d;

    logic [IDX_W-1:0]    gamma, lambda;
    logic                col_major;
    logic [CNT_W-1:0]    total;
    logic                last_pair;
    logic [NUM_CH-1:0]   pick_onehot;
    logic [PW-1:0]       pick_idx;
    logic                pick_valid;
    logic [NUM_CH-1:0]   ready;
    logic [NUM_CH-1:0]   hs;
    logic [NUM_CH-1:0]   res_ok;
    logic [NUM_CH-1:0]   res_spur;
    logic [CNT_W-1:0]    res_inc;
    logic [DATA_W-1:0]   status;
    logic [DATA_W+CNT_W-1:0] cnt_ext;

    assign gamma     = config_q[IDX_W-1:0];
    assign lambda    = config_q[2*IDX_W-1:IDX_W];
    assign col_major = config_q[CFG_ORDER_BIT];
    assign total     = CNT_W'(gamma) * CNT_W'(lambda);
    // Compare against dim-1 so gamma = lambda = 2^IDX_W-1 never needs a wider counter.
    assign last_pair = (row_q == gamma - 1'b1) && (col_q == lambda - 1'b1);

    rr_pick #(
        .N  (NUM_CH),
        .PW (PW)
    ) u_rr_pick (
        .i_Free   (~busy_q),
        .i_Ptr    (ptr_q),
        .o_Onehot (pick_onehot),
        .o_Index  (pick_idx),
        .o_Valid  (pick_valid)
    );

    // The offer depends only on registered state, so it stays put until the
    // accepting channel acknowledges it.
    assign ready    = (state_q == ST_DISPATCH && pick_valid) ? pick_onehot : '0;
    assign hs       = ready & i_Indexes_Received;
    // A result arriving in the same cycle as the handshake belongs to the pair
    // just accepted; it is counted and the busy bit is still set.
    assign res_ok   = i_Result_Ready & (busy_q | hs);
    assign res_spur = i_Result_Ready & ~busy_q & ~hs;

    always_comb begin
        res_inc = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            res_inc = res_inc + CNT_W'(res_ok[c]);
        end
    end

    assign cnt_ext = {{DATA_W{1'b0}}, res_cnt_q};

    always_comb begin
        status                        = '0;
        status[STAT_DONE_BIT]         = 1'b1;
        status[STAT_ERR_DIM_BIT]      = err_dim_q;
        status[STAT_ERR_SPUR_BIT]     = err_spur_q;
        status[DATA_W-1:STAT_CNT_LSB] = cnt_ext[DATA_W-STAT_CNT_LSB-1:0];
    end

    always_comb begin
        state_d          = state_q;
        config_d         = config_q;
        row_d            = row_q;
        col_d            = col_q;
        busy_d           = busy_q;
        ptr_d            = ptr_q;
        res_cnt_d        = res_cnt_q;
        err_dim_d        = err_dim_q;
        err_spur_d       = err_spur_q;
        o_Grant_Request  = 1'b0;
        o_Memory_Address = '0;
        o_Mem_Data       = '0;
        o_Write_Enable   = 1'b0;

        if (state_q != ST_IDLE) begin
            busy_d    = (busy_q & ~res_ok) | hs;
            res_cnt_d = res_cnt_q + res_inc;
            if (|res_spur) begin
                err_spur_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_Data_Ready) begin
                    state_d    = ST_REQ;
                    busy_d     = '0;
                    ptr_d      = '0;
                    res_cnt_d  = '0;
                    err_dim_d  = 1'b0;
                    err_spur_d = 1'b0;
                end
            end
            ST_REQ: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                o_Grant_Request  = 1'b1;
                o_Memory_Address = ADDR_W'(CFG_ADDR);
                state_d          = i_Grant ? ST_RD_DATA : ST_REQ;
            end
            ST_RD_DATA: begin
                o_Grant_Request = 1'b1;
                if (!i_Grant) begin
                    state_d = ST_REQ;
                end else begin
                    config_d = i_Mem_Data;
                    row_d    = '0;
                    col_d    = '0;
                    if (i_Mem_Data[IDX_W-1:0] == '0 || i_Mem_Data[2*IDX_W-1:IDX_W] == '0) begin
                        err_dim_d = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        state_d   = ST_DISPATCH;
                    end
                end
            end
            ST_DISPATCH: begin
                if (|hs) begin
                    ptr_d = PW'(next_ptr(int'(pick_idx), NUM_CH));
                    if (!col_major) begin
                        if (col_q == lambda - 1'b1) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        if (row_q == gamma - 1'b1) begin
                            row_d = '0;
                            col_d = col_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                    if (last_pair) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (res_cnt_q == total && busy_q == '0) begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                o_Grant_Request  = 1'b1;
                o_Memory_Address = ADDR_W'(STATUS_ADDR);
                o_Mem_Data       = status;
                if (i_Grant) begin
                    o_Write_Enable = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!i_Data_Ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            config_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= '0;
            ptr_q      <= '0;
            res_cnt_q  <= '0;
            err_dim_q  <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            config_q   <= config_d;
            row_q      <= row_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            res_cnt_q  <= res_cnt_d;
            err_dim_q  <= err_dim_d;
            err_spur_q <= err_spur_d;
        end
    end

    always_comb begin
        o_Row_Index    = '0;
        o_Column_Index = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ready[c]) begin
                o_Row_Index[c*IDX_W +: IDX_W]    = row_q;
                o_Column_Index[c*IDX_W +: IDX_W] = col_q;
            end
        end
    end

    assign o_Indexes_Ready = ready;
    assign o_Config        = config_q;
    assign o_Busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_main_cu_multi.sv
// Scoreboard bench for main_cu_multi: jobs push expected pairs and status
// words; a monitor pops them on each pair handshake and status write.
module tb_main_cu_multi;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic                    i_Clock = 1'b0;
    logic                    i_Reset;
    logic                    i_Data_Ready;
    logic                    i_Grant;
    logic [DATA_W-1:0]       i_Mem_Data;
    logic [NUM_CH-1:0]       i_Indexes_Received;
    logic [NUM_CH-1:0]       i_Result_Ready;
    logic                    o_Grant_Request;
    logic [ADDR_W-1:0]       o_Memory_Address;
    logic [DATA_W-1:0]       o_Mem_Data;
    logic                    o_Write_Enable;
    logic [DATA_W-1:0]       o_Config;
    logic [NUM_CH-1:0]       o_Indexes_Ready;
    logic [NUM_CH*IDX_W-1:0] o_Row_Index;
    logic [NUM_CH*IDX_W-1:0] o_Column_Index;
    logic                    o_Busy;

    main_cu_multi #(
        .NUM_CH(NUM_CH), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .CFG_ADDR(0), .STATUS_ADDR(1)
    ) dut (
        .i_Clock            (i_Clock),
        .i_Reset            (i_Reset),
        .i_Data_Ready       (i_Data_Ready),
        .i_Grant            (i_Grant),
        .i_Mem_Data         (i_Mem_Data),
        .i_Indexes_Received (i_Indexes_Received),
        .i_Result_Ready     (i_Result_Ready),
        .o_Grant_Request    (o_Grant_Request),
        .o_Memory_Address   (o_Memory_Address),
        .o_Mem_Data         (o_Mem_Data),
        .o_Write_Enable     (o_Write_Enable),
        .o_Config           (o_Config),
        .o_Indexes_Ready    (o_Indexes_Ready),
        .o_Row_Index        (o_Row_Index),
        .o_Column_Index     (o_Column_Index),
        .o_Busy             (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        int r;
        int c;
        int ch;
    } pair_t;

    pair_t       pair_q[$];
    logic [31:0] stat_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int hs_job      = 0;

    logic [31:0] cfg_word  = 32'h0;
    localparam logic [31:0] BOGUS_CFG = 32'h0000_0101;
    bit rst_req   = 1'b1;
    bit drop_pend = 1'b0;
    bit spur_pend = 1'b0;
    int fix_ack   = -1;
    int fix_res   = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Bus arbiter, memory and channel models, all updated on the falling edge.
    int ch_st[NUM_CH];
    int ch_t[NUM_CH];
    int req_n;
    int d;

    initial begin
        i_Reset            = 1'b1;
        i_Grant            = 1'b0;
        i_Mem_Data         = '0;
        i_Indexes_Received = '0;
        i_Result_Ready     = '0;
        req_n              = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_st[c] = 0;
            ch_t[c]  = 0;
        end
        forever begin
            @(negedge i_Clock);
            i_Reset            = rst_req;
            i_Indexes_Received = '0;
            i_Result_Ready     = '0;
            i_Mem_Data         = drop_pend ? BOGUS_CFG : cfg_word;
            if (rst_req) begin
                i_Grant = 1'b0;
                req_n   = 0;
                for (int c = 0; c < NUM_CH; c++) ch_st[c] = 0;
            end else begin
                if (o_Grant_Request) begin
                    i_Grant = !(drop_pend && req_n == 2);
                    if (drop_pend && req_n == 2) drop_pend = 1'b0;
                    if (spur_pend && req_n == 1) begin
                        i_Result_Ready[2] = 1'b1;
                        spur_pend = 1'b0;
                    end
                    req_n++;
                end else begin
                    i_Grant = 1'b0;
                    req_n   = 0;
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    case (ch_st[c])
                        0: if (o_Indexes_Ready[c]) begin
                            d = (fix_ack >= 0) ? fix_ack : int'($urandom_range(0, 3));
                            if (d == 0) begin
                                i_Indexes_Received[c] = 1'b1;
                                ch_st[c] = 2;
                                ch_t[c]  = (fix_res >= 0) ? fix_res : int'($urandom_range(1, 6));
                            end else begin
                                ch_st[c] = 1;
                                ch_t[c]  = d;
                            end
                        end
                        1: begin
                            ch_t[c]--;
                            if (ch_t[c] == 0) begin
                                i_Indexes_Received[c] = 1'b1;
                                ch_st[c] = 2;
                                ch_t[c]  = (fix_res >= 0) ? fix_res : int'($urandom_range(1, 6));
                            end
                        end
                        default: begin
                            ch_t[c]--;
                            if (ch_t[c] == 0) begin
                                i_Result_Ready[c] = 1'b1;
                                ch_st[c] = 0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Monitor: pops expectations on each pair handshake and each status write.
    pair_t p;
    initial begin
        forever begin
            @(negedge i_Clock);
            #2;
            if (!i_Reset) begin
                if (o_Indexes_Ready != '0) begin
                    check("ready_onehot", 64'($countones(o_Indexes_Ready)), 64'd1);
                    if (pair_q.size() == 0) fail_now("unexpected_ready");
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (o_Indexes_Ready[c] && i_Indexes_Received[c] && pair_q.size() != 0) begin
                            p = pair_q.pop_front();
                            check("row_index", 64'(o_Row_Index[c*IDX_W +: IDX_W]), 64'(p.r));
                            check("col_index", 64'(o_Column_Index[c*IDX_W +: IDX_W]), 64'(p.c));
                            if (p.ch >= 0) check("rr_channel", 64'(c), 64'(p.ch));
                            hs_job++;
                        end
                    end
                end
                if (o_Write_Enable) begin
                    if (stat_q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        check("status_addr", 64'(o_Memory_Address), 64'd1);
                        check("status_word", 64'(o_Mem_Data), 64'(stat_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, 64'(|{o_Grant_Request, o_Memory_Address, o_Mem_Data, o_Write_Enable,
                          o_Config, o_Indexes_Ready, o_Row_Index, o_Column_Index, o_Busy}), 64'd0);
    endtask

    task automatic load_job(input int g, input int l, input int ord, input bit chk_ch);
        pair_t q;
        int    k = 0;
        cfg_word = {ord[0], 15'h0, 8'(l), 8'(g)};
        if (g != 0 && l != 0) begin
            if (ord == 0) begin
                for (int r = 0; r < g; r++)
                    for (int c = 0; c < l; c++) begin
                        q.r = r; q.c = c; q.ch = chk_ch ? (k % NUM_CH) : -1;
                        pair_q.push_back(q);
                        k++;
                    end
            end else begin
                for (int c = 0; c < l; c++)
                    for (int r = 0; r < g; r++) begin
                        q.r = r; q.c = c; q.ch = chk_ch ? (k % NUM_CH) : -1;
                        pair_q.push_back(q);
                        k++;
                    end
            end
        end
    endtask

    task automatic run_job(input int g, input int l, input int ord, input bit spur, input bit drop,
                           input int fa, input int fr, input bit chk_ch, input bit chk_lat);
        logic [31:0] st;
        bit          dimerr;
        int          lat;
        fix_ack = fa;
        fix_res = fr;
        load_job(g, l, ord, chk_ch);
        dimerr = (g == 0 || l == 0);
        st = 32'h1;
        if (dimerr) st[1] = 1'b1;
        if (spur)   st[2] = 1'b1;
        if (!dimerr) st[31:16] = 16'(g * l);
        stat_q.push_back(st);
        spur_pend = spur;
        drop_pend = drop;
        hs_job    = 0;
        @(posedge i_Clock); #1;
        i_Data_Ready = 1'b1;
        if (chk_lat) begin
            lat = 0;
            for (int n = 1; n <= 10 && lat == 0; n++) begin
                @(posedge i_Clock); #1;
                if (o_Indexes_Ready != '0) lat = n;
            end
            check("first_ready_latency", 64'(lat), 64'd4);
        end
        for (int k = 0; k < 20000 && stat_q.size() != 0; k++) begin
            @(posedge i_Clock); #1;
        end
        if (stat_q.size() != 0) begin
            fail_now("job_timeout");
            stat_q.delete();
        end
        check("pairs_left", 64'(pair_q.size()), 64'd0);
        pair_q.delete();
        check("config_latched", 64'(o_Config), 64'(cfg_word));
        repeat (3) @(posedge i_Clock);
        #1;
        check("done_holds_on_level", 64'(o_Busy), 64'd1);
        i_Data_Ready = 1'b0;
        repeat (2) @(posedge i_Clock);
        #1;
        check("back_to_idle", 64'(o_Busy), 64'd0);
    endtask

    task automatic reset_mid_job();
        fix_ack = 1;
        fix_res = 3;
        load_job(3, 4, 0, 1'b0);
        hs_job = 0;
        @(posedge i_Clock); #1;
        i_Data_Ready = 1'b1;
        for (int k = 0; k < 2000 && hs_job < 4; k++) begin
            @(posedge i_Clock); #1;
        end
        check("reached_4_pairs", 64'(hs_job >= 4), 64'd1);
        rst_req      = 1'b1;
        i_Data_Ready = 1'b0;
        @(posedge i_Clock); #1;
        check_all_zero("mid_reset_outputs");
        pair_q.delete();
        stat_q.delete();
        rst_req = 1'b0;
        @(posedge i_Clock); #1;
    endtask

    initial begin
        i_Data_Ready = 1'b0;
        rst_req      = 1'b1;
        repeat (3) @(posedge i_Clock);
        #1;
        check_all_zero("reset_outputs");
        rst_req = 1'b0;
        repeat (2) @(posedge i_Clock);

        run_job(3, 3, 0, 1'b0, 1'b0, 2, 5, 1'b1, 1'b1);
        run_job(2, 3, 1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
        run_job(0, 5, 0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
        run_job(4, 0, 1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
        run_job(2, 2, 0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        run_job(2, 3, 0, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
        reset_mid_job();
        run_job(2, 2, 1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
        run_job(255, 1, 1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
        run_job(1, 255, 0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
        for (int t = 0; t < 16; t++) begin
            run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), -1, -1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
